// File: rtl/eda_strobe_bank_pkg.sv
// eda_strobe_bank_pkg: default geometry of the strobe bank plus the shared
// FSM state and bank-select types.
`ifndef CFG_M
`define CFG_M 4
`endif
`ifndef CFG_N
`define CFG_N 4
`endif
`ifndef CFG_ADDR_WIDTH
`define CFG_ADDR_WIDTH 4
`endif
`ifndef CFG_J_WIDTH
`define CFG_J_WIDTH 2
`endif

package eda_strobe_bank_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_HOLD} state_t;
   typedef enum logic {BANK0, BANK1} bank_sel_t;
endpackage

// File: rtl/eda_row_ffs.sv
// eda_row_ffs: lowest set column of one row at or above a start-column mask.
module eda_row_ffs #(
   parameter int N  = 4,
   parameter int CW = 2
) (
   input  logic [N-1:0]  vec,
   input  logic [N-1:0]  mask,
   output logic          hit,
   output logic [CW-1:0] col
);
   always_comb begin
      hit = 1'b0;
      col = '0;
      for (int c = N - 1; c >= 0; c--)
         if (vec[c] && mask[c]) begin
            hit = 1'b1;
            col = CW'(c);
         end
   end
endmodule

// File: rtl/eda_strobe_bank.sv
// eda_strobe_bank: double-buffered bit bank; writes go to the write bank,
// a row-per-cycle scanner hands out set bits of the read bank.
module eda_strobe_bank
   import eda_strobe_bank_pkg::*;
#(
   parameter int M          = `CFG_M,
   parameter int N          = `CFG_N,
   parameter int ADDR_WIDTH = `CFG_ADDR_WIDTH,
   parameter int J_WIDTH    = `CFG_J_WIDTH,
   parameter int CNT_WIDTH  = $clog2(M * N + 1)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic [ADDR_WIDTH-1:0] seed_addr,
   input  logic                  mark_en,
   input  logic [ADDR_WIDTH-1:0] mark_addr,
   input  logic                  unmark_en,
   input  logic [ADDR_WIDTH-1:0] unmark_addr,
   input  logic                  swap,
   input  logic                  scan_req,
   input  logic                  scan_from_start,
   output logic                  next_valid,
   output logic [ADDR_WIDTH-1:0] next_addr,
   input  logic                  next_ready,
   output logic                  scan_empty,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  set_count,
   output logic [M-1:0][N-1:0]   strb_value,
   output logic                  addr_err,
   output logic                  swap_err
);
   localparam int RW = ADDR_WIDTH - J_WIDTH;
   localparam logic [M-1:0][N-1:0] RST_BANK = {{(M * N - 1){1'b0}}, 1'b1};

   logic [M-1:0][N-1:0] bank0, bank1, bank0_n, bank1_n, wr_bank, wr_bank_n, rd_bank;
   bank_sel_t wsel, wsel_n;
   state_t state, state_n;
   logic [RW-1:0] m_row, u_row, s_row, scan_row, start_row;
   logic [J_WIDTH-1:0] m_col, u_col, s_col, hit_col;
   logic [J_WIDTH:0] scan_col, start_col;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [N-1:0] col_mask;
   logic m_ok, u_ok, s_ok, cur_v, hit, last_row, swap_ok, accept;

   assign {m_row, m_col} = mark_addr;
   assign {u_row, u_col} = unmark_addr;
   assign {s_row, s_col} = seed_addr;
   assign m_ok = int'(m_row) < M && int'(m_col) < N;
   assign u_ok = int'(u_row) < M && int'(u_col) < N;
   assign s_ok = int'(s_row) < M && int'(s_col) < N;

   assign wr_bank = (wsel == BANK0) ? bank0 : bank1;
   assign rd_bank = (wsel == BANK0) ? bank1 : bank0;
   assign busy = state != ST_IDLE;
   assign next_valid = state == ST_HOLD;
   assign accept = next_valid && next_ready;
   assign swap_ok = swap && !busy;
   assign last_row = int'(scan_row) == M - 1;

   // Unmark is applied before mark so a same-address pair leaves the bit set.
   always_comb begin
      wr_bank_n = wr_bank;
      if (clear) begin
         wr_bank_n = '0;
         if (s_ok) wr_bank_n[s_row][s_col] = 1'b1;
      end else begin
         if (unmark_en && u_ok) wr_bank_n[u_row][u_col] = 1'b0;
         if (mark_en && m_ok) wr_bank_n[m_row][m_col] = 1'b1;
      end
   end

   assign wsel_n  = swap_ok ? bank_sel_t'(~wsel) : wsel;
   assign bank0_n = (wsel == BANK0) ? wr_bank_n : bank0;
   assign bank1_n = (wsel == BANK1) ? wr_bank_n : bank1;

   always_comb begin
      set_count = '0;
      for (int i = 0; i < M; i++)
         for (int k = 0; k < N; k++)
            set_count = set_count + CNT_WIDTH'(wr_bank[i][k]);
   end

   // Resume point: one past the cursor, which may fall off the row end.
   assign start_row = (scan_from_start || !cur_v) ? '0 : cur_addr[ADDR_WIDTH-1:J_WIDTH];
   assign start_col = (scan_from_start || !cur_v) ? '0 : {1'b0, cur_addr[J_WIDTH-1:0]} + 1'b1;

   always_comb begin
      col_mask = '0;
      for (int c = 0; c < N; c++)
         col_mask[c] = c >= int'(scan_col);
   end

   eda_row_ffs #(.N(N), .CW(J_WIDTH)) u_ffs (
      .vec (rd_bank[scan_row]),
      .mask(col_mask),
      .hit (hit),
      .col (hit_col)
   );

   always_comb begin
      state_n = state;
      if (state == ST_IDLE) state_n = scan_req ? ST_SCAN : ST_IDLE;
      else if (state == ST_SCAN) state_n = hit ? ST_HOLD : last_row ? ST_IDLE : ST_SCAN;
      else state_n = next_ready ? ST_IDLE : ST_HOLD;
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= ST_IDLE;
      else state <= state_n;

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         bank0      <= RST_BANK;
         bank1      <= '0;
         wsel       <= BANK0;
         strb_value <= '0;
         addr_err   <= 1'b0;
         swap_err   <= 1'b0;
         scan_empty <= 1'b0;
         scan_row   <= '0;
         scan_col   <= '0;
         next_addr  <= '0;
         cur_addr   <= '0;
         cur_v      <= 1'b0;
      end else begin
         bank0      <= bank0_n;
         bank1      <= bank1_n;
         wsel       <= wsel_n;
         strb_value <= (wsel_n == BANK0) ? bank1_n : bank0_n;
         addr_err   <= clear ? !s_ok : addr_err | (mark_en & !m_ok) | (unmark_en & !u_ok);
         swap_err   <= clear ? 1'b0 : swap_err | (swap & busy);
         scan_empty <= state == ST_SCAN && !hit && last_row;
         if (state == ST_IDLE && scan_req) begin
            scan_row <= start_row;
            scan_col <= start_col;
         end else if (state == ST_SCAN) begin
            scan_row <= scan_row + 1'b1;
            scan_col <= '0;
         end
         if (state == ST_SCAN && hit) next_addr <= {scan_row, hit_col};
         if (accept) begin
            cur_addr <= next_addr;
            cur_v    <= 1'b1;
         end else if (swap_ok) cur_v <= 1'b0;
      end
endmodule

// File: tb/tb_eda_strobe_bank.sv
// tb_eda_strobe_bank: directed sequence with a flat bank model and a queue of
// expected scan results for the 4x4 bank, plus a 4x3 instance for range errors.
module tb_eda_strobe_bank;
   logic clk = 1'b0;
   logic reset_n, clear, mark_en, unmark_en, swap, scan_req, scan_from_start, next_ready;
   logic [3:0] seed_addr, mark_addr, unmark_addr, next_addr;
   logic next_valid, scan_empty, busy, addr_err, swap_err;
   logic [4:0] set_count;
   logic [3:0][3:0] strb_value;
   logic clear2, mark2_en;
   logic [3:0] mark2_addr, next_addr2;
   logic next_valid2, scan_empty2, busy2, addr_err2, swap_err2;
   logic [3:0] set_count2;
   logic [3:0][2:0] strb_value2;
   logic [15:0] m_wb, m_rb;
   int m_cur, checks, errors;
   int exp_q[$];

   always #5 clk = ~clk;

   eda_strobe_bank dut (
      .clk(clk), .reset_n(reset_n), .clear(clear), .seed_addr(seed_addr),
      .mark_en(mark_en), .mark_addr(mark_addr), .unmark_en(unmark_en), .unmark_addr(unmark_addr),
      .swap(swap), .scan_req(scan_req), .scan_from_start(scan_from_start),
      .next_valid(next_valid), .next_addr(next_addr), .next_ready(next_ready),
      .scan_empty(scan_empty), .busy(busy), .set_count(set_count), .strb_value(strb_value),
      .addr_err(addr_err), .swap_err(swap_err)
   );

   eda_strobe_bank #(.M(4), .N(3), .ADDR_WIDTH(4), .J_WIDTH(2)) dut3 (
      .clk(clk), .reset_n(reset_n), .clear(clear2), .seed_addr(4'd0),
      .mark_en(mark2_en), .mark_addr(mark2_addr), .unmark_en(1'b0), .unmark_addr(4'd0),
      .swap(1'b0), .scan_req(1'b0), .scan_from_start(1'b0),
      .next_valid(next_valid2), .next_addr(next_addr2), .next_ready(1'b0),
      .scan_empty(scan_empty2), .busy(busy2), .set_count(set_count2), .strb_value(strb_value2),
      .addr_err(addr_err2), .swap_err(swap_err2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input string tag, input bit me, input logic [3:0] ma, input bit ue, input logic [3:0] ua);
      mark_en = me; mark_addr = ma; unmark_en = ue; unmark_addr = ua;
      tick();
      mark_en = 1'b0; unmark_en = 1'b0;
      if (ue) m_wb[ua] = 1'b0;
      if (me) m_wb[ma] = 1'b1;
      chk(tag, set_count, $countones(m_wb));
      chk({tag, "_strb"}, strb_value, m_rb);
   endtask

   task automatic do_swap();
      swap = 1'b1;
      tick();
      swap = 1'b0;
      {m_wb, m_rb} = {m_rb, m_wb};
      m_cur = -1;
      chk("swap_strb", strb_value, m_rb);
      chk("swap_cnt", set_count, $countones(m_wb));
   endtask

   task automatic do_clear(input logic [3:0] s);
      clear = 1'b1; seed_addr = s; mark_en = 1'b1; mark_addr = 4'd3;
      tick();
      clear = 1'b0; mark_en = 1'b0;
      m_wb = 16'h1 << s;
      chk("clear_cnt", set_count, 1);
      chk("clear_swap_err", swap_err, 0);
   endtask

   task automatic scan(input bit fs, input int hold, input bit sw_hold);
      int sa, sr, a, rows, lat, got, exp;
      sa = fs ? 0 : m_cur + 1;
      sr = (fs || m_cur < 0) ? 0 : m_cur / 4;
      a = sa;
      while (a < 16 && !m_rb[a]) a++;
      rows = (a < 16) ? a / 4 - sr + 1 : 4 - sr;
      exp_q.push_back(a < 16 ? a : -1);
      scan_from_start = fs; scan_req = 1'b1;
      tick();
      scan_req = 1'b0;
      lat = 1;
      while (!next_valid && !scan_empty && lat < 20) begin
         tick();
         lat++;
      end
      got = next_valid ? int'(next_addr) : scan_empty ? -1 : -2;
      exp = exp_q.pop_front();
      chk("scan_addr", got, exp);
      chk("scan_lat", lat, rows + 1);
      if (next_valid) begin
         for (int i = 0; i < hold; i++) begin
            swap = sw_hold && i == 0;
            tick();
            swap = 1'b0;
            chk("hold_valid", next_valid, 1);
            chk("hold_addr", next_addr, got);
         end
         if (sw_hold) begin
            chk("swap_err", swap_err, 1);
            chk("strb_no_swap", strb_value, m_rb);
         end
         next_ready = 1'b1;
         tick();
         next_ready = 1'b0;
         chk("accept", {next_valid, busy}, 0);
         m_cur = got;
      end else begin
         tick();
         chk("empty_pulse", scan_empty, 0);
         chk("empty_idle", busy, 0);
      end
   endtask

   initial begin
      checks = 0; errors = 0;
      reset_n = 1'b0; clear = 1'b0; seed_addr = '0; mark_en = 1'b0; mark_addr = '0;
      unmark_en = 1'b0; unmark_addr = '0; swap = 1'b0; scan_req = 1'b0;
      scan_from_start = 1'b0; next_ready = 1'b0; clear2 = 1'b0; mark2_en = 1'b0; mark2_addr = '0;
      repeat (3) tick();
      reset_n = 1'b1;
      m_wb = 16'h0001; m_rb = 16'h0000; m_cur = -1;
      tick();
      chk("rst_cnt", set_count, 1);
      chk("rst_strb", strb_value, 0);
      chk("rst_busy", busy, 0);
      chk("rst_flags", {next_valid, scan_empty, addr_err, swap_err}, 0);
      chk("rst_addr", next_addr, 0);
      do_swap();
      wr("mark5", 1, 4'd5, 0, 4'd0);
      wr("mark10", 1, 4'd10, 0, 4'd0);
      wr("mark15", 1, 4'd15, 0, 4'd0);
      do_swap();
      scan(1, 0, 0);
      scan(0, 0, 0);
      scan(0, 0, 0);
      scan(0, 0, 0);
      scan(1, 0, 0);
      wr("mark_unmark6", 1, 4'd6, 1, 4'd6);
      wr("remark6", 1, 4'd6, 0, 4'd0);
      wr("unmark0_mark7", 1, 4'd7, 1, 4'd0);
      wr("unmark0_again", 0, 4'd0, 1, 4'd0);
      wr("unmark6", 0, 4'd0, 1, 4'd6);
      do_clear(4'd9);
      wr("mark12", 1, 4'd12, 0, 4'd0);
      do_swap();
      scan(0, 5, 1);
      scan(0, 0, 0);
      do_clear(4'd2);
      wr("unmark2", 0, 4'd0, 1, 4'd2);
      do_swap();
      scan(1, 0, 0);
      chk("main_addr_err", addr_err, 0);
      chk("n3_rst", {addr_err2, set_count2}, 5'h01);
      mark2_en = 1'b1; mark2_addr = 4'd3;
      tick();
      mark2_en = 1'b0;
      chk("n3_err", addr_err2, 1);
      chk("n3_nowrite", set_count2, 1);
      mark2_en = 1'b1; mark2_addr = 4'd2;
      tick();
      mark2_en = 1'b0;
      chk("n3_err_sticky", addr_err2, 1);
      chk("n3_valid_mark", set_count2, 2);
      clear2 = 1'b1;
      tick();
      clear2 = 1'b0;
      chk("n3_err_clr", {addr_err2, set_count2}, 5'h01);
      wr("mark15b", 1, 4'd15, 0, 4'd0);
      do_swap();
      scan_from_start = 1'b1; scan_req = 1'b1;
      tick();
      scan_req = 1'b0;
      tick();
      chk("mid_scan_busy", busy, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_busy", busy, 0);
      chk("async_out", {next_valid, scan_empty, addr_err, swap_err}, 0);
      chk("async_strb", strb_value, 0);
      chk("async_cnt", set_count, 1);
      chk("async_addr", next_addr, 0);
      tick();
      reset_n = 1'b1;
      m_wb = 16'h0001; m_rb = 16'h0000; m_cur = -1;
      scan(1, 0, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
